id_hazard_forward_unit: RTL and testbench
=========================================

Name: id_hazard_forward_unit

Overview:
- Parametrised successor to the stall-only ID-stage hazard logic in the pipelined CPU.
- Tracks in-flight destination registers of the EX, MEM and WB stages in an internal scoreboard, so it no longer depends on per-stage address/enable inputs.
- Chooses per-operand bypass sources and generates stalls for load-use and ID-resolved branches.
- Sits between the register file read ports and the ID/EX pipeline register. It also keeps stall and forward performance counters.

Parameters:
- ADDR_W, 5, register address width; register 0 is hard-wired zero.
- DATA_W, 32, operand data width.
- FWD_EN, 1, 1 = full forwarding; 0 = legacy stall-only mode (WB bypass still active).
- CNT_W, 32, performance counter width.

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- id_valid  in  1  ID holds a real instruction
- id_rs_addr  in  ADDR_W  rs source address
- id_rt_addr  in  ADDR_W  rt source address
- id_rs_rena  in  1  rs is read
- id_rt_rena  in  1  rt is read
- id_is_branch  in  1  instruction compares operands in ID (beq/bne)
- id_wena  in  1  ID instruction writes a register
- id_waddr  in  ADDR_W  ID instruction destination
- id_is_load  in  1  ID instruction is a load
- flush  in  1  kill the ID instruction this cycle
- rf_rs_data  in  DATA_W  register file rs read data
- rf_rt_data  in  DATA_W  register file rt read data
- ex_result  in  DATA_W  ALU result of the EX-stage instruction
- mem_result  in  DATA_W  ALU result held in the MEM stage
- wb_data  in  DATA_W  write-back data, including load data
- rs_data_out  out  DATA_W  resolved rs operand
- rt_data_out  out  DATA_W  resolved rt operand
- fwd_rs_sel  out  2  rs source select: 0 RF, 1 EX, 2 MEM, 3 WB
- fwd_rt_sel  out  2  rt source select, same encoding
- stall  out  1  hold PC and IF/ID; insert bubble into EX
- stall_count  out  CNT_W  cycles stalled
- fwd_count  out  CNT_W  issued instructions that used any bypass

Behaviour:
- Scoreboard: three slots, EX, MEM and WB. Each slot holds {valid, waddr, wena, is_load}.
- Scoreboard update at each rising edge:
  - WB<=MEM and MEM<=EX.
  - If stall or flush or !id_valid: EX<=bubble (valid=0).
  - Otherwise: EX<={1, id_waddr, id_wena, id_is_load}.
- Per-operand match: an operand matches a slot when rena=1, addr!=0, slot.valid and slot.wena, and slot.waddr==addr.
- Match priority: EX > MEM > WB. Only the youngest matching slot is considered.
- Resolution with FWD_EN=1:
  - EX match and EX.is_load: stall.
  - EX match and id_is_branch: stall (no EX-to-branch-compare path).
  - EX match otherwise: sel=1.
  - MEM match and MEM.is_load: stall (load data only valid in WB).
  - MEM match otherwise: sel=2.
  - WB match: sel=3.
  - No match: sel=0.
- Resolution with FWD_EN=0:
  - EX or MEM match: stall.
  - WB match: sel=3.
  - No match: sel=0.
- stall = id_valid & !flush & (rs needs stall | rt needs stall).
- When stall=1 the sel outputs are don't-care; the bench checks them only when stall=0.
- Data outputs are a combinational mux on sel, with zero latency.
- Worst-case stalls per dependency:
  - Load-use: 2 cycles, then sel=3.
  - Branch on ALU result: 1 cycle, then sel=2.
  - Branch on load result: 2 cycles, then sel=3.
  - FWD_EN=0 back-to-back dependency: 2 cycles, then sel=3.
- flush has priority over stall. With flush=1: stall=0, EX gets a bubble, counters hold.
- Counters:
  - stall_count increments on every cycle with stall=1.
  - fwd_count increments on every issue cycle (id_valid & !stall & !flush) with any sel!=0.
  - Both saturate at all-ones.
- Reset:
  - All slot valids clear; both counters clear.
  - Outputs settle combinationally to stall=0, sel=0 and RF pass-through.
  - Reset asserted mid-stall drops stall in the cycle after the reset edge.

Decomposition:
- Package id_hazard_pkg holds:
  - The fwd_sel encoding constants FWD_RF, FWD_EX, FWD_MEM, FWD_WB.
  - The scoreboard slot struct type.
- One sub-module, hazard_operand_resolve, is instantiated twice (rs, rt).
  - Inputs: addr, rena, the three slots, id_is_branch, FWD_EN.
  - Outputs: sel and need_stall.
- The top level owns the scoreboard shift, the data muxes and the counters.

Test Plan:
- add r1(EX, ex_result=0x5) then add r2,r1,r0 in ID -> stall=0, fwd_rs_sel=1, rs_data_out=0x00000005, fwd_count=1.
- lw r3 then add r4,r3,r3 -> stall=1 for 2 cycles (stall_count=2); third cycle fwd_rs_sel=fwd_rt_sel=3, both outputs=wb_data 0xDEADBEEF.
- add r5 then beq r5,r0 (id_is_branch=1) -> 1 stall cycle, then fwd_rs_sel=2 with rs_data_out=mem_result.
- Write to r0 followed by a read of r0 -> no stall, sel=0, rs_data_out=rf_rs_data.
- FWD_EN=0: back-to-back add dependency -> 2 stall cycles, then sel=3. Separately, flush=1 during a would-be stall -> stall=0, EX bubble, counters unchanged.
- Reset asserted in the first cycle of a load-use stall -> next cycle stall=0, stall_count=0, fwd_count=0, all slots empty.

Source files
------------

// File: rtl/id_hazard_pkg.sv
// Shared encodings and scoreboard slot layout for the ID-stage hazard/forward unit.
package id_hazard_pkg;

    localparam logic [1:0] FWD_RF  = 2'd0;
    localparam logic [1:0] FWD_EX  = 2'd1;
    localparam logic [1:0] FWD_MEM = 2'd2;
    localparam logic [1:0] FWD_WB  = 2'd3;

    // Slot address field is sized for the widest supported register file.
    localparam int SB_ADDR_W = 8;

    typedef struct packed {
        logic                 valid;
        logic [SB_ADDR_W-1:0] waddr;
        logic                 wena;
        logic                 is_load;
    } sb_slot_t;

endpackage

// File: rtl/id_hazard_forward_unit_resolve.sv
// Per-operand resolution: picks the youngest in-flight producer and decides bypass vs stall.
module hazard_operand_resolve
    import id_hazard_pkg::*;
#(
    parameter int ADDR_W = 5,
    parameter bit FWD_EN = 1'b1
) (
    input  logic [ADDR_W-1:0] addr,
    input  logic              rena,
    input  sb_slot_t          ex_slot,
    input  sb_slot_t          mem_slot,
    input  sb_slot_t          wb_slot,
    input  logic              id_is_branch,
    output logic [1:0]        sel,
    output logic              need_stall
);

    logic ex_hit, mem_hit, wb_hit;

    function automatic logic hit(input sb_slot_t s, input logic [ADDR_W-1:0] a, input logic re);
        return re && (a != '0) && s.valid && s.wena && (s.waddr == SB_ADDR_W'(a));
    endfunction

    assign ex_hit  = hit(ex_slot,  addr, rena);
    assign mem_hit = hit(mem_slot, addr, rena);
    assign wb_hit  = hit(wb_slot,  addr, rena);

    always_comb begin
        sel        = FWD_RF;
        need_stall = 1'b0;
        if (ex_hit) begin
            // Branches compare in ID, so there is no path from the ALU output that cycle.
            if (!FWD_EN || ex_slot.is_load || id_is_branch) need_stall = 1'b1;
            else                                             sel        = FWD_EX;
        end else if (mem_hit) begin
            if (!FWD_EN || mem_slot.is_load) need_stall = 1'b1;
            else                             sel        = FWD_MEM;
        end else if (wb_hit) begin
            sel = FWD_WB;
        end
    end

endmodule

// File: rtl/id_hazard_forward_unit.sv
// ID-stage hazard unit: internal EX/MEM/WB scoreboard, operand bypass muxes, stall and perf counters.
module id_hazard_forward_unit
    import id_hazard_pkg::*;
#(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32,
    parameter bit FWD_EN = 1'b1,
    parameter int CNT_W  = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              id_valid,
    input  logic [ADDR_W-1:0] id_rs_addr,
    input  logic [ADDR_W-1:0] id_rt_addr,
    input  logic              id_rs_rena,
    input  logic              id_rt_rena,
    input  logic              id_is_branch,
    input  logic              id_wena,
    input  logic [ADDR_W-1:0] id_waddr,
    input  logic              id_is_load,
    input  logic              flush,
    input  logic [DATA_W-1:0] rf_rs_data,
    input  logic [DATA_W-1:0] rf_rt_data,
    input  logic [DATA_W-1:0] ex_result,
    input  logic [DATA_W-1:0] mem_result,
    input  logic [DATA_W-1:0] wb_data,
    output logic [DATA_W-1:0] rs_data_out,
    output logic [DATA_W-1:0] rt_data_out,
    output logic [1:0]        fwd_rs_sel,
    output logic [1:0]        fwd_rt_sel,
    output logic              stall,
    output logic [CNT_W-1:0]  stall_count,
    output logic [CNT_W-1:0]  fwd_count
);

    sb_slot_t ex_q, mem_q, wb_q, ex_next;
    logic     rs_stall, rt_stall, issue, used_fwd;

    hazard_operand_resolve #(.ADDR_W(ADDR_W), .FWD_EN(FWD_EN)) u_rs (
        .addr(id_rs_addr), .rena(id_rs_rena),
        .ex_slot(ex_q), .mem_slot(mem_q), .wb_slot(wb_q),
        .id_is_branch(id_is_branch), .sel(fwd_rs_sel), .need_stall(rs_stall)
    );

    hazard_operand_resolve #(.ADDR_W(ADDR_W), .FWD_EN(FWD_EN)) u_rt (
        .addr(id_rt_addr), .rena(id_rt_rena),
        .ex_slot(ex_q), .mem_slot(mem_q), .wb_slot(wb_q),
        .id_is_branch(id_is_branch), .sel(fwd_rt_sel), .need_stall(rt_stall)
    );

    assign stall    = id_valid & ~flush & (rs_stall | rt_stall);
    assign issue    = id_valid & ~flush & ~stall;
    assign used_fwd = (fwd_rs_sel != FWD_RF) | (fwd_rt_sel != FWD_RF);

    function automatic logic [DATA_W-1:0] pick(input logic [1:0] sel, input logic [DATA_W-1:0] rf);
        case (sel)
            FWD_EX:  return ex_result;
            FWD_MEM: return mem_result;
            FWD_WB:  return wb_data;
            default: return rf;
        endcase
    endfunction

    assign rs_data_out = pick(fwd_rs_sel, rf_rs_data);
    assign rt_data_out = pick(fwd_rt_sel, rf_rt_data);

    always_comb begin
        ex_next = '0;
        if (issue) begin
            ex_next.valid   = 1'b1;
            ex_next.waddr   = SB_ADDR_W'(id_waddr);
            ex_next.wena    = id_wena;
            ex_next.is_load = id_is_load;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            ex_q        <= '0;
            mem_q       <= '0;
            wb_q        <= '0;
            stall_count <= '0;
            fwd_count   <= '0;
        end else begin
            ex_q  <= ex_next;
            mem_q <= ex_q;
            wb_q  <= mem_q;
            if (stall && stall_count != '1)
                stall_count <= stall_count + 1'b1;
            if (issue && used_fwd && fwd_count != '1)
                fwd_count <= fwd_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_id_hazard_forward_unit.sv
// Directed-vector bench: forwarding instance and a stall-only (FWD_EN=0) instance on shared stimulus.
module tb_id_hazard_forward_unit;

    logic        clock = 1'b0;
    logic        reset1, reset0;
    logic        id_valid, id_rs_rena, id_rt_rena, id_is_branch, id_wena, id_is_load, flush;
    logic [4:0]  id_rs_addr, id_rt_addr, id_waddr;
    logic [31:0] rf_rs_data, rf_rt_data, ex_result, mem_result, wb_data;

    logic [31:0] rs1, rt1, rs0, rt0, sc1, fc1, sc0, fc0;
    logic [1:0]  rsel1, tsel1, rsel0, tsel0;
    logic        st1, st0;

    int vectors = 0;
    int miscompares = 0;

    always #5 clock = ~clock;

    id_hazard_forward_unit #(.FWD_EN(1'b1)) dut1 (
        .clock(clock), .reset(reset1), .id_valid(id_valid),
        .id_rs_addr(id_rs_addr), .id_rt_addr(id_rt_addr),
        .id_rs_rena(id_rs_rena), .id_rt_rena(id_rt_rena), .id_is_branch(id_is_branch),
        .id_wena(id_wena), .id_waddr(id_waddr), .id_is_load(id_is_load), .flush(flush),
        .rf_rs_data(rf_rs_data), .rf_rt_data(rf_rt_data), .ex_result(ex_result),
        .mem_result(mem_result), .wb_data(wb_data),
        .rs_data_out(rs1), .rt_data_out(rt1), .fwd_rs_sel(rsel1), .fwd_rt_sel(tsel1),
        .stall(st1), .stall_count(sc1), .fwd_count(fc1)
    );

    id_hazard_forward_unit #(.FWD_EN(1'b0)) dut0 (
        .clock(clock), .reset(reset0), .id_valid(id_valid),
        .id_rs_addr(id_rs_addr), .id_rt_addr(id_rt_addr),
        .id_rs_rena(id_rs_rena), .id_rt_rena(id_rt_rena), .id_is_branch(id_is_branch),
        .id_wena(id_wena), .id_waddr(id_waddr), .id_is_load(id_is_load), .flush(flush),
        .rf_rs_data(rf_rs_data), .rf_rt_data(rf_rt_data), .ex_result(ex_result),
        .mem_result(mem_result), .wb_data(wb_data),
        .rs_data_out(rs0), .rt_data_out(rt0), .fwd_rs_sel(rsel0), .fwd_rt_sel(tsel0),
        .stall(st0), .stall_count(sc0), .fwd_count(fc0)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic instr(input logic v, input logic [4:0] rs, input logic rse,
                         input logic [4:0] rt, input logic rte, input logic br,
                         input logic we, input logic [4:0] wa, input logic ld);
        id_valid = v; id_rs_addr = rs; id_rs_rena = rse; id_rt_addr = rt; id_rt_rena = rte;
        id_is_branch = br; id_wena = we; id_waddr = wa; id_is_load = ld;
    endtask

    task automatic idle();
        instr(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
    endtask

    task automatic step(input int n = 1);
        repeat (n) @(negedge clock);
    endtask

    initial begin
        reset1 = 1'b1; reset0 = 1'b1; flush = 1'b0;
        idle();
        rf_rs_data = 32'h1111_1111; rf_rt_data = 32'h2222_2222;
        ex_result  = 32'h0000_0005; mem_result = 32'h0000_1234; wb_data = 32'hDEAD_BEEF;
        step(2);
        reset1 = 1'b0; #1;
        chk("rst_stall", {31'd0, st1}, 32'd0);
        chk("rst_rs_sel", {30'd0, rsel1}, 32'd0);
        chk("rst_rt_sel", {30'd0, tsel1}, 32'd0);
        chk("rst_rs_data", rs1, 32'h1111_1111);
        chk("rst_rt_data", rt1, 32'h2222_2222);
        chk("rst_counts", sc1 | fc1, 32'd0);

        // add r1 ; add r2,r1,r0 -> EX bypass
        instr(1, 0, 0, 0, 0, 0, 1, 1, 0); step();
        instr(1, 1, 1, 0, 1, 0, 1, 2, 0); #1;
        chk("ex_fwd_stall", {31'd0, st1}, 32'd0);
        chk("ex_fwd_sel", {30'd0, rsel1}, 32'd1);
        chk("ex_fwd_rt_sel", {30'd0, tsel1}, 32'd0);
        chk("ex_fwd_data", rs1, 32'h0000_0005);
        step(); idle(); #1;
        chk("ex_fwd_count", fc1, 32'd1);
        step(3);

        // lw r3 ; add r4,r3,r3 -> 2 stalls then WB bypass
        instr(1, 0, 0, 0, 0, 0, 1, 3, 1); step();
        instr(1, 3, 1, 3, 1, 0, 1, 4, 0); #1;
        chk("lu_stall_c1", {31'd0, st1}, 32'd1);
        step(); #1;
        chk("lu_stall_c2", {31'd0, st1}, 32'd1);
        chk("lu_scount_1", sc1, 32'd1);
        step(); #1;
        chk("lu_stall_c3", {31'd0, st1}, 32'd0);
        chk("lu_scount_2", sc1, 32'd2);
        chk("lu_rs_sel", {30'd0, rsel1}, 32'd3);
        chk("lu_rt_sel", {30'd0, tsel1}, 32'd3);
        chk("lu_rs_data", rs1, 32'hDEAD_BEEF);
        chk("lu_rt_data", rt1, 32'hDEAD_BEEF);
        step(); idle(); #1;
        chk("lu_fcount", fc1, 32'd2);
        step(3);

        // add r5 ; beq r5,r0 -> 1 stall then MEM bypass
        instr(1, 0, 0, 0, 0, 0, 1, 5, 0); step();
        instr(1, 5, 1, 0, 1, 1, 0, 0, 0); #1;
        chk("br_stall_c1", {31'd0, st1}, 32'd1);
        step(); #1;
        chk("br_stall_c2", {31'd0, st1}, 32'd0);
        chk("br_rs_sel", {30'd0, rsel1}, 32'd2);
        chk("br_rs_data", rs1, 32'h0000_1234);
        chk("br_scount", sc1, 32'd3);
        step(); idle(); #1;
        chk("br_fcount", fc1, 32'd3);
        step(3);

        // write r0 ; read r0 -> no hazard
        instr(1, 0, 0, 0, 0, 0, 1, 0, 0); step();
        instr(1, 0, 1, 0, 1, 0, 1, 6, 0); #1;
        chk("r0_stall", {31'd0, st1}, 32'd0);
        chk("r0_rs_sel", {30'd0, rsel1}, 32'd0);
        chk("r0_rs_data", rs1, 32'h1111_1111);
        step(); idle(); #1;
        chk("r0_fcount", fc1, 32'd3);
        step(3);

        // ALU producer reaching WB -> WB bypass
        instr(1, 0, 0, 0, 0, 0, 1, 7, 0); step();
        idle(); step(2);
        instr(1, 0, 0, 7, 1, 0, 0, 0, 0); #1;
        chk("wb_alu_stall", {31'd0, st1}, 32'd0);
        chk("wb_alu_rt_sel", {30'd0, tsel1}, 32'd3);
        chk("wb_alu_rt_data", rt1, 32'hDEAD_BEEF);
        step(); idle(); step(3);

        // reset in first cycle of a load-use stall
        instr(1, 0, 0, 0, 0, 0, 1, 3, 1); step();
        instr(1, 3, 1, 3, 1, 0, 1, 4, 0); #1;
        chk("rs_pre_stall", {31'd0, st1}, 32'd1);
        reset1 = 1'b1; step(); reset1 = 1'b0; #1;
        chk("rs_post_stall", {31'd0, st1}, 32'd0);
        chk("rs_post_scount", sc1, 32'd0);
        chk("rs_post_fcount", fc1, 32'd0);
        chk("rs_post_sel", {28'd0, rsel1, tsel1}, 32'd0);
        chk("rs_post_data", rs1, 32'h1111_1111);

        // stall-only instance
        reset1 = 1'b1; idle(); step();
        reset0 = 1'b0; #1;
        chk("f0_rst_stall", {31'd0, st0}, 32'd0);
        chk("f0_rst_counts", sc0 | fc0, 32'd0);
        instr(1, 0, 0, 0, 0, 0, 1, 1, 0); step();
        instr(1, 1, 1, 0, 1, 0, 1, 2, 0); #1;
        chk("f0_stall_c1", {31'd0, st0}, 32'd1);
        step(); #1;
        chk("f0_stall_c2", {31'd0, st0}, 32'd1);
        step(); #1;
        chk("f0_stall_c3", {31'd0, st0}, 32'd0);
        chk("f0_rs_sel", {30'd0, rsel0}, 32'd3);
        chk("f0_rs_data", rs0, 32'hDEAD_BEEF);
        chk("f0_scount", sc0, 32'd2);
        step(); idle(); #1;
        chk("f0_fcount", fc0, 32'd1);
        step(3);

        // flush during would-be stall: no stall, EX bubble, counters hold
        instr(1, 0, 0, 0, 0, 0, 1, 3, 0); step();
        instr(1, 3, 1, 0, 0, 0, 1, 4, 0); flush = 1'b1; #1;
        chk("fl_stall", {31'd0, st0}, 32'd0);
        step(); flush = 1'b0;
        instr(1, 4, 1, 0, 0, 0, 1, 9, 0); #1;
        chk("fl_scount", sc0, 32'd2);
        chk("fl_fcount", fc0, 32'd1);
        chk("fl_bubble_stall", {31'd0, st0}, 32'd0);
        chk("fl_bubble_sel", {30'd0, rsel0}, 32'd0);
        chk("fl_bubble_data", rs0, 32'h1111_1111);
        step(); idle(); step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
